siso_word_deserializer: RTL

//  Receive end of the 16-bit SISO shift-register link: samples the serial Dout stream
//  and reassembles it into parallel words, honouring the source shift direction (Left).

---
 rtl/siso_word_deserializer_pkg.sv | 8 +
 rtl/siso_word_deserializer_if.sv | 20 ++
 rtl/siso_word_deserializer_fifo.sv | 46 ++++
 rtl/siso_word_deserializer.sv | 93 +++++++++
 4 files changed

// File: rtl/siso_word_deserializer_pkg.sv
// Shared types and defaults for the SISO word deserializer and its output FIFO.
package siso_pkg;
   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 2;

   typedef enum logic {IDLE, COLLECT} rx_state_e;
   typedef logic [WIDTH_DEF-1:0] word_t;
endpackage

// File: rtl/siso_word_deserializer_if.sv
// Serial input side and parallel word output side of the deserializer.
interface siso_word_deserializer_if #(parameter int WIDTH = 16);
   localparam int CW = $clog2(WIDTH) + 1;

   logic             En;
   logic             Din;
   logic             Left;
   logic             Sync;
   logic             Word_ready;
   logic             Ovf_clr;
   logic [WIDTH-1:0] Word_out;
   logic             Word_valid;
   logic [CW-1:0]    Bit_count;
   logic             Overflow;

   modport master (output En, Din, Left, Sync, Word_ready, Ovf_clr,
                   input  Word_out, Word_valid, Bit_count, Overflow);
   modport slave  (input  En, Din, Left, Sync, Word_ready, Ovf_clr,
                   output Word_out, Word_valid, Bit_count, Overflow);
endinterface

// File: rtl/siso_word_deserializer_fifo.sv
// Small register FIFO; the head word is always visible on dout.
module siso_word_fifo
   import siso_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             w_do_pop;
   logic             w_do_push;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_do_pop  = pop && !empty;
   // A full FIFO still takes a word when the head leaves on the same edge.
   assign w_do_push = push && (!full || w_do_pop);
   assign dout      = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= din;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/siso_word_deserializer.sv
// Reassembles the serial Dout stream of the shift-register link into parallel words.
module siso_word_deserializer
   import siso_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                 Clk,
   input  logic                 Rst,
   siso_word_deserializer_if.slave bus
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   rx_state_e        r_state, w_state_next;
   logic [CW-1:0]    r_count, w_count_next;
   logic             r_dir, w_dir_next;
   logic [WIDTH-1:0] r_sr, w_sr_next;
   logic             r_ovf;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic [WIDTH-1:0] w_dout;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state <= IDLE;
         r_count <= '0;
         r_dir   <= 1'b0;
         r_sr    <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         r_dir   <= w_dir_next;
         r_sr    <= w_sr_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_count_next = r_count;
      w_dir_next   = r_dir;
      w_sr_next    = r_sr;
      w_push       = 1'b0;
      // First bit of a word (also after Sync) fixes the direction for the whole word.
      if (bus.En && (bus.Sync || r_state == IDLE)) begin
         w_state_next = COLLECT;
         w_count_next = CW'(1);
         w_dir_next   = bus.Left;
         w_sr_next    = bus.Left ? {{(WIDTH-1){1'b0}}, bus.Din}
                                 : {bus.Din, {(WIDTH-1){1'b0}}};
      end else if (bus.Sync) begin
         w_state_next = IDLE;
         w_count_next = '0;
      end else if (bus.En) begin
         w_sr_next = r_dir ? {r_sr[WIDTH-2:0], bus.Din}
                           : {bus.Din, r_sr[WIDTH-1:1]};
         if (r_count == LAST_BIT) begin
            w_push       = 1'b1;
            w_state_next = IDLE;
            w_count_next = '0;
         end else begin
            w_count_next = r_count + 1'b1;
         end
      end
   end

   assign w_pop = bus.Word_ready && !w_empty;

   // A dropped word beats a simultaneous clear.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)                            r_ovf <= 1'b0;
      else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (bus.Ovf_clr)                r_ovf <= 1'b0;
   end

   siso_word_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .Clk   (Clk),
      .Rst   (Rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_sr_next),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   assign bus.Word_out   = w_dout;
   assign bus.Word_valid = !w_empty;
   assign bus.Bit_count  = r_count;
   assign bus.Overflow   = r_ovf;
endmodule
